// File: rtl/led_arbiter_if.sv
// LED ownership bus between the two requesters and led_arbiter.
// master = requester side, slave = arbiter side.
interface led_arbiter_if;
    logic       cpu_req;
    logic [1:0] cpu_led;
    logic       cpu_gnt;
    logic       hw_req;
    logic [1:0] hw_led;
    logic       hw_gnt;
    logic [1:0] ledr;
    logic [1:0] owner;

    modport master (
        output cpu_req, cpu_led, hw_req, hw_led,
        input  cpu_gnt, hw_gnt, ledr, owner
    );

    modport slave (
        input  cpu_req, cpu_led, hw_req, hw_led,
        output cpu_gnt, hw_gnt, ledr, owner
    );
endinterface

// File: rtl/led_arbiter.sv
// Red LED arbiter: CPU vs hardware owner with hold-time preemption and heartbeat
// blink, plus synchronized/debounced switch inputs (sw_db[0] enables the arbiter).
module led_debounce #(
    parameter int CYCLES = 1_000_000
) (
    input  logic clk_clk,
    input  logic reset_reset_n,
    input  logic raw,
    output logic db
);
    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic          s1, s2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            db  <= 1'b0;
            cnt <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            // s1 != s2 means the synchronized bit is about to change: restart the count
            if (s2 == db || s1 != s2) begin
                cnt <= '0;
            end else if (cnt == CW'(CYCLES - 1)) begin
                db  <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module led_arbiter #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int HOLD_CYCLES     = 25_000_000,
    parameter int BLINK_HALF      = 12_500_000
) (
    input  logic          clk_clk,
    input  logic          reset_reset_n,
    input  logic [1:0]    sw_raw,
    output logic [1:0]    sw_db,
    led_arbiter_if.slave  bus
);
    localparam int NUM_SW = 2;
    localparam int HW_W   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int BW     = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CPU  = 2'b01,
        S_HW   = 2'b10
    } state_t;

    state_t          state, state_nxt;
    logic [HW_W-1:0] hold_cnt;
    logic [BW-1:0]   blink_cnt;
    logic            blink;
    logic [1:0]      ledr_nxt;
    logic            en;
    logic            hold_max;

    for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
        led_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk_clk       (clk_clk),
            .reset_reset_n (reset_reset_n),
            .raw           (sw_raw[i]),
            .db            (sw_db[i])
        );
    end

    assign en       = sw_db[0];
    assign hold_max = (hold_cnt == HW_W'(HOLD_CYCLES - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (bus.hw_req)       state_nxt = S_HW;
                else if (bus.cpu_req) state_nxt = S_CPU;
            end
            // Release beats preemption: owner dropping its request always idles.
            S_CPU: begin
                if (!bus.cpu_req)               state_nxt = S_IDLE;
                else if (bus.hw_req && hold_max) state_nxt = S_HW;
            end
            S_HW: begin
                if (!bus.hw_req)                 state_nxt = S_IDLE;
                else if (bus.cpu_req && hold_max) state_nxt = S_CPU;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (!en) state_nxt = S_IDLE;

        ledr_nxt = 2'b00;
        case (state_nxt)
            S_CPU:   ledr_nxt = bus.cpu_led;
            S_HW:    ledr_nxt = bus.hw_led;
            default: ledr_nxt = en ? {1'b0, blink} : 2'b00;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state       <= S_IDLE;
            hold_cnt    <= '0;
            blink_cnt   <= '0;
            blink       <= 1'b0;
            bus.owner   <= 2'b00;
            bus.cpu_gnt <= 1'b0;
            bus.hw_gnt  <= 1'b0;
            bus.ledr    <= 2'b00;
        end else begin
            state       <= state_nxt;
            bus.owner   <= state_nxt;
            bus.cpu_gnt <= (state_nxt == S_CPU);
            bus.hw_gnt  <= (state_nxt == S_HW);
            bus.ledr    <= ledr_nxt;

            if (state_nxt != state)
                hold_cnt <= '0;
            else if (state != S_IDLE && !hold_max)
                hold_cnt <= hold_cnt + 1'b1;

            if (blink_cnt == BW'(BLINK_HALF - 1)) begin
                blink_cnt <= '0;
                blink     <= ~blink;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_led_arbiter.sv
// Bench for led_arbiter: hand sequences for reset/debounce/async reset, plus a
// per-cycle vector table whose expectations flow through a scoreboard queue.
module tb_led_arbiter;
    localparam logic [1:0] O_I = 2'b00, O_C = 2'b01, O_H = 2'b10;

    typedef struct {
        logic [1:0] sw;
        logic       cr;
        logic [1:0] cl;
        logic       hr;
        logic [1:0] hl;
        logic       ecg;
        logic       ehg;
        logic [1:0] eown;
        logic [1:0] eled;
        logic       hb;
        logic [1:0] esw;
    } vec_t;

    typedef struct {
        int         idx;
        logic       ecg;
        logic       ehg;
        logic [1:0] eown;
        logic [1:0] eled;
        logic       hb;
        logic [1:0] esw;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] sw_raw;
    logic [1:0] sw_db;
    int         checks = 0;
    int         errors = 0;
    int         ecnt;
    vec_t       tbl[$];
    exp_t       sb[$];

    led_arbiter_if bus();

    led_arbiter #(.DEBOUNCE_CYCLES(4), .HOLD_CYCLES(8), .BLINK_HALF(3)) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .sw_raw        (sw_raw),
        .sw_db         (sw_db),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    // Edges since reset release; the heartbeat phase is derived from it.
    always @(posedge clk or negedge rst_n)
        if (!rst_n) ecnt <= 0;
        else        ecnt <= ecnt + 1;

    task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %b want %b", nm, act, exp);
        end
    endtask

    task automatic add(input logic [1:0] sw, input logic cr, input logic [1:0] cl,
                       input logic hr, input logic [1:0] hl, input logic ecg,
                       input logic ehg, input logic [1:0] eown, input logic [1:0] eled,
                       input logic hb, input logic [1:0] esw);
        vec_t v;
        v.sw = sw; v.cr = cr; v.cl = cl; v.hr = hr; v.hl = hl;
        v.ecg = ecg; v.ehg = ehg; v.eown = eown; v.eled = eled; v.hb = hb; v.esw = esw;
        tbl.push_back(v);
    endtask

    // Scoreboard consumer: one expectation per clock edge while the table runs.
    always @(posedge clk) begin
        exp_t e;
        logic [1:0] led_exp;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            led_exp = e.hb ? {1'b0, (((ecnt - 1) / 3) % 2) != 0} : e.eled;
            chk($sformatf("r%0d cpu_gnt", e.idx), {1'b0, bus.cpu_gnt}, {1'b0, e.ecg});
            chk($sformatf("r%0d hw_gnt", e.idx), {1'b0, bus.hw_gnt}, {1'b0, e.ehg});
            chk($sformatf("r%0d owner", e.idx), bus.owner, e.eown);
            chk($sformatf("r%0d ledr", e.idx), bus.ledr, led_exp);
            chk($sformatf("r%0d sw_db", e.idx), sw_db, e.esw);
            chk($sformatf("r%0d gnt_mutex", e.idx), {1'b0, bus.cpu_gnt & bus.hw_gnt}, 2'b00);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        sw_raw = 2'b01;
        bus.cpu_req = 1'b0; bus.cpu_led = 2'b00;
        bus.hw_req  = 1'b0; bus.hw_led  = 2'b00;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst sw_db", sw_db, 2'b00);
        chk("rst ledr", bus.ledr, 2'b00);
        chk("rst owner", bus.owner, O_I);
        chk("rst gnts", {bus.cpu_gnt, bus.hw_gnt}, 2'b00);

        // Enable debounce: sw_db changes on exactly the 6th edge
        rst_n = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            @(posedge clk); #1;
            chk($sformatf("debounce edge%0d", n), sw_db, (n == 6) ? 2'b01 : 2'b00);
            chk($sformatf("disabled ledr edge%0d", n), bus.ledr, 2'b00);
        end

        // r0-r5: idle heartbeat with a 3-cycle glitch on sw_raw[1]
        for (int k = 0; k < 3; k++) add(2'b11, 0, 2'b00, 0, 2'b00, 0, 0, O_I, 2'b00, 1, 2'b01);
        for (int k = 0; k < 3; k++) add(2'b01, 0, 2'b00, 0, 2'b00, 0, 0, O_I, 2'b00, 1, 2'b01);
        // r6: simultaneous requests -> HW
        add(2'b01, 1, 2'b01, 1, 2'b10, 0, 1, O_H, 2'b10, 0, 2'b01);
        for (int k = 0; k < 7; k++) begin
            logic [1:0] hl;
            hl = k[0] ? 2'b10 : 2'b11;
            add(2'b01, 1, 2'b01, 1, hl, 0, 1, O_H, hl, 0, 2'b01);
        end
        // r14: preempt to CPU after 8 owned cycles
        add(2'b01, 1, 2'b01, 1, 2'b10, 1, 0, O_C, 2'b01, 0, 2'b01);
        for (int k = 0; k < 7; k++) begin
            logic [1:0] cl;
            cl = k[0] ? 2'b01 : 2'b11;
            add(2'b01, 1, cl, 1, 2'b10, 1, 0, O_C, cl, 0, 2'b01);
        end
        // r22: back to HW
        add(2'b01, 1, 2'b01, 1, 2'b10, 0, 1, O_H, 2'b10, 0, 2'b01);
        // r23: HW releases while CPU waits -> one idle bubble
        add(2'b01, 1, 2'b01, 0, 2'b10, 0, 0, O_I, 2'b00, 1, 2'b01);
        add(2'b01, 1, 2'b01, 0, 2'b10, 1, 0, O_C, 2'b01, 0, 2'b01);
        // r25: CPU releases while HW requests -> idle, heartbeat
        add(2'b01, 0, 2'b01, 1, 2'b11, 0, 0, O_I, 2'b00, 1, 2'b01);
        add(2'b01, 0, 2'b01, 1, 2'b11, 0, 1, O_H, 2'b11, 0, 2'b01);
        add(2'b01, 1, 2'b01, 1, 2'b11, 0, 1, O_H, 2'b11, 0, 2'b01);
        // r28-r33: disable ripples through debounce while HW owns
        for (int k = 0; k < 6; k++)
            add(2'b00, 1, 2'b01, 1, 2'b11, 0, 1, O_H, 2'b11, 0, (k == 5) ? 2'b00 : 2'b01);
        // r34: disable coincides with hold expiry -> disable wins
        add(2'b00, 1, 2'b01, 1, 2'b11, 0, 0, O_I, 2'b00, 0, 2'b00);
        for (int k = 0; k < 5; k++) add(2'b01, 0, 2'b01, 1, 2'b11, 0, 0, O_I, 2'b00, 0, 2'b00);
        add(2'b01, 0, 2'b01, 1, 2'b11, 0, 0, O_I, 2'b00, 0, 2'b01);
        add(2'b01, 0, 2'b01, 1, 2'b10, 0, 1, O_H, 2'b10, 0, 2'b01);

        for (int i = 0; i < tbl.size(); i++) begin
            exp_t e;
            @(negedge clk);
            sw_raw = tbl[i].sw;
            bus.cpu_req = tbl[i].cr; bus.cpu_led = tbl[i].cl;
            bus.hw_req  = tbl[i].hr; bus.hw_led  = tbl[i].hl;
            e.idx = i; e.ecg = tbl[i].ecg; e.ehg = tbl[i].ehg; e.eown = tbl[i].eown;
            e.eled = tbl[i].eled; e.hb = tbl[i].hb; e.esw = tbl[i].esw;
            sb.push_back(e);
        end
        repeat (2) @(posedge clk);
        #2;
        chk("scoreboard drained", (sb.size() == 0) ? 2'b01 : 2'b00, 2'b01);

        // Asynchronous reset mid-ownership, away from any clock edge
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async hw_gnt", {1'b0, bus.hw_gnt}, 2'b00);
        chk("async cpu_gnt", {1'b0, bus.cpu_gnt}, 2'b00);
        chk("async ledr", bus.ledr, 2'b00);
        chk("async owner", bus.owner, O_I);
        chk("async sw_db", sw_db, 2'b00);
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/led_arbiter.md
# led_arbiter

Shares the board's two red LEDs between the Nios LED PIO path (CPU requester) and a hardware status requester, and supplies debounced switch values to the switch PIO. Sits in the hello_world top between MAX10_CLK1_50, SW/LEDR and the nios_setup_v2 instance. Arbitration is fixed-priority with a hold-time preemption rule. A heartbeat blink drives the LEDs when no requester owns them.

## Interface
- DEBOUNCE_CYCLES, 1_000_000: cycles a synchronized switch bit must stay stable before `sw_db` updates (20 ms at 50 MHz).
- HOLD_CYCLES, 25_000_000: ownership cycles after which a waiting requester preempts the owner.
- BLINK_HALF, 12_500_000: heartbeat half-period in cycles.
- clk_clk  in  1  system clock (MAX10_CLK1_50).
- reset_reset_n  in  1  reset; asynchronous assert, active-low.
- sw_raw  in  2  raw SW pins, asynchronous.
- sw_db  out  2  debounced switches to the switch PIO; `sw_db[0]` is also the arbiter enable.
- cpu_req  in  1  CPU requests the LEDs (level).
- cpu_led  in  2  CPU LED value.
- cpu_gnt  out  1  CPU owns the LEDs.
- hw_req  in  1  hardware requests the LEDs (level).
- hw_led  in  2  hardware LED value.
- hw_gnt  out  1  hardware owns the LEDs.
- ledr  out  2  LED drive.
- owner  out  2  current owner: 00 IDLE, 01 CPU, 10 HW.

## Operation
- **Switch input path**
  - Each `sw_raw` bit passes through a 2-FF synchronizer, then its own debounce counter.
  - The counter clears whenever the synchronized bit equals `sw_db` or changes value.
  - When the counter reaches DEBOUNCE_CYCLES-1 with the bit still differing, `sw_db` takes the new value and the counter clears.
- **State machine:** IDLE, CPU, HW.
- **IDLE**
  - `hw_req` goes to HW. `cpu_req` alone goes to CPU. Both together go to HW (hardware priority).
  - LEDs show the heartbeat: `ledr = {1'b0, blink}`.
- **CPU or HW (owner state)**
  - Owner request low: go to IDLE. This applies even if the other side is requesting, and costs one bubble cycle.
  - Owner request high, other side requesting, and `hold_cnt == HOLD_CYCLES-1`: go directly to the other owner. There is no IDLE cycle in between.
  - Otherwise stay in the current state.
- **hold_cnt**
  - Clears on every state change.
  - Increments while in CPU or HW and saturates at HOLD_CYCLES-1.
  - Stays 0 in IDLE.
- **Enable (`sw_db[0]`)**
  - While `sw_db[0]==0`, the next state is forced to IDLE, both grants are 0 and `ledr` is 2'b00 (heartbeat suppressed).
  - The blink counter keeps running.
- **Blink counter**
  - Counts 0..BLINK_HALF-1 and wraps.
  - On the wrap, `blink` toggles.
- **Register updates:** `cpu_gnt`, `hw_gnt`, `owner` and `ledr` are all registered from the next state. `ledr` loads the next owner's data input, or the heartbeat value, or 0.

## Timing
- **Reset values:** state IDLE, `owner` 00, `cpu_gnt`/`hw_gnt` 0, `ledr` 00, `sw_db` 00, all counters 0, `blink` 0, synchronizers 0.
- Because `sw_db[0]` resets to 0, the arbiter starts disabled.
- **Request to grant:** a request sampled high at edge k gives the grant asserted after edge k. `ledr` shows the owner's data from that same edge.
- **Data tracking:** while owned, `ledr` follows the owner's data with 1-cycle latency.
- **Request release:** request low at edge k gives grant low and `owner`=00 after edge k, and the heartbeat appears on `ledr` from that edge.
- **Preemption:** one grant deasserts and the other asserts on the same edge. Both grants are never high together.
- **Switch latency:** a clean `sw_raw` change reaches `sw_db` after 2 + DEBOUNCE_CYCLES edges.
- **Glitches:** a glitch shorter than DEBOUNCE_CYCLES never changes `sw_db`.
- **Reset mid-operation:** all outputs return to reset values immediately, without waiting for a clock edge.
- **Simultaneous events**
  - Preemption and owner release on the same edge: release wins and the next state is IDLE.
  - Disable and preemption on the same edge: disable wins.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, HOLD_CYCLES=8, BLINK_HALF=3.

1. **Reset and enable debounce:** hold reset, then release with `sw_raw`=01. Required: `sw_db`=01 exactly 6 edges after the first sampling edge, then `ledr[0]` toggles every 3 cycles.
2. **Glitch rejection:** with `sw_db`=01, pulse `sw_raw[1]` high for 3 cycles. Required: `sw_db` stays 01.
3. **Simultaneous requests:** `cpu_req`=`hw_req`=1 in IDLE with `hw_led`=10. Required: `hw_gnt`=1, `owner`=10, `ledr`=10 after one edge, and `cpu_gnt` stays 0.
4. **Preemption:** keep both requests high. Required: after 8 owned cycles `hw_gnt` falls and `cpu_gnt` rises on the same edge, and `ledr`=`cpu_led`=01. The grant returns to HW 8 cycles later.
5. **Release and disable**
   - Drop `cpu_req` while CPU owns. Required: `owner`=00 and the heartbeat resumes on the next edge.
   - Then drive `sw_raw[0]`=0 while HW owns. Required: once `sw_db[0]` falls, `hw_gnt`=0 and `ledr`=00.
6. **Reset mid-operation:** assert `reset_reset_n` low while HW owns. Required: `hw_gnt`=0, `ledr`=00 and `owner`=00 asynchronously, without a clock edge.
